// File: rtl/image_stream_loader_if.sv
// Pixel stream carrying one signed pixel per beat plus an end-of-frame marker.
// Latency: none, wires only.
// Backpressure: a beat moves only when s_valid and s_ready are both high on a clock edge.
interface image_stream_loader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         s_valid;
    logic signed [DATA_WIDTH-1:0] s_data;
    logic                         s_last;
    logic                         s_ready;

    // Producer side drives the pixel; it samples ready.
    modport master (output s_valid, output s_data, output s_last, input s_ready);
    // Loader side receives the pixel; it drives ready.
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/image_stream_loader.sv
// Loads one frame of pixels into a row/column buffer, then starts the fetcher and waits for it to finish.
// Latency: a pixel lands in image_data one cycle after acceptance; start_comp is high in the cycle after the final beat.
// Backpressure: s_ready is registered and stays low from the final beat until the fetcher raises comp_ready again.
module image_stream_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ARRAY_A_W  = 1,
    parameter int ARRAY_A_L  = 784
) (
    input  logic                         clk,
    input  logic                         reset_n,
    image_stream_loader_if.slave         s_if,
    output logic                         start_comp,
    input  logic                         comp_ready,
    output logic signed [DATA_WIDTH-1:0] image_data [0:ARRAY_A_W-1][0:ARRAY_A_L-1],
    output logic                         frame_done,
    output logic                         frame_err
);

    localparam int RW = (ARRAY_A_W > 1) ? $clog2(ARRAY_A_W) : 1;
    localparam int CW = (ARRAY_A_L > 1) ? $clog2(ARRAY_A_L) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ARRAY_A_W - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(ARRAY_A_L - 1);

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          s_ready_q, s_ready_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic          comp_prev_q, comp_prev_d;
    logic          wait_first_q, wait_first_d;
    logic signed [DATA_WIDTH-1:0] image_q [0:ARRAY_A_W-1][0:ARRAY_A_L-1];
    logic signed [DATA_WIDTH-1:0] image_d [0:ARRAY_A_W-1][0:ARRAY_A_L-1];

    logic accept;
    logic last_pos;
    logic comp_rise;

    assign accept    = (state_q == LOAD) && s_if.s_valid && s_ready_q;
    assign last_pos  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    // The first WAIT_DONE cycle may still see a level left over from the previous frame, so it is masked.
    assign comp_rise = comp_ready && !comp_prev_q && !wait_first_q;

    // Next-state, buffer write and pulse generation.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        comp_prev_d  = comp_ready;
        wait_first_d = 1'b0;
        image_d      = image_q;

        case (state_q)
            LOAD: begin
                if (accept) begin
                    image_d[row_q][col_q] = s_if.s_data;
                    if (last_pos) begin
                        // A full frame always completes; a missing s_last is only reported.
                        state_d     = START;
                        frame_err_d = !s_if.s_last;
                    end else if (s_if.s_last) begin
                        // Short frame: keep the written pixel, flag it, restart at column 0.
                        frame_err_d = 1'b1;
                        row_d       = '0;
                        col_d       = '0;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            START: begin
                state_d      = WAIT_DONE;
                wait_first_d = 1'b1;
            end
            WAIT_DONE: begin
                if (comp_rise) begin
                    frame_done_d = 1'b1;
                    row_d        = '0;
                    col_d        = '0;
                    state_d      = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        s_ready_d = (state_d == LOAD);
    end

    // State and buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= LOAD;
            row_q        <= '0;
            col_q        <= '0;
            s_ready_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            comp_prev_q  <= 1'b0;
            wait_first_q <= 1'b0;
            image_q      <= '{default: '0};
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            s_ready_q    <= s_ready_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            comp_prev_q  <= comp_prev_d;
            wait_first_q <= wait_first_d;
            image_q      <= image_d;
        end
    end

    assign s_if.s_ready = s_ready_q;
    assign start_comp   = (state_q == START);
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;
    assign image_data   = image_q;

endmodule

// File: tb/tb_image_stream_loader.sv
// Bench for image_stream_loader: directed and randomised frames against a pixel-index model.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: beats are offered until s_ready takes them, within a bounded wait.
module tb_image_stream_loader;

    localparam int DW = 16;
    localparam int AW = 1;
    localparam int AL = 4;
    localparam int N  = AW * AL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic start_comp;
    logic comp_ready;
    logic frame_done;
    logic frame_err;
    logic signed [DW-1:0] img [0:AW-1][0:AL-1];

    image_stream_loader_if #(.DATA_WIDTH(DW)) bus ();

    image_stream_loader #(
        .DATA_WIDTH(DW),
        .ARRAY_A_W (AW),
        .ARRAY_A_L (AL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_if      (bus.slave),
        .start_comp(start_comp),
        .comp_ready(comp_ready),
        .image_data(img),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    int checks = 0;
    int errors = 0;
    int n_start = 0;
    int n_done = 0;
    int n_err = 0;
    int exp_img [0:AW-1][0:AL-1];
    int k = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_img(input string tag);
        for (int r = 0; r < AW; r++)
            for (int c = 0; c < AL; c++)
                check(tag, img[r][c], exp_img[r][c]);
    endtask

    task automatic clear_model();
        for (int r = 0; r < AW; r++)
            for (int c = 0; c < AL; c++)
                exp_img[r][c] = 0;
        k = 0;
    endtask

    // One clock: advance past the edge, then tally the pulses seen after it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (start_comp === 1'b1) n_start++;
        if (frame_done === 1'b1) n_done++;
        if (frame_err  === 1'b1) n_err++;
    endtask

    task automatic idle(input int n);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = DW'($urandom);
        repeat (n) tick();
    endtask

    // Offer one beat until taken; the model places beat k at [k / AL][k % AL].
    task automatic send_beat(input int v, input bit last);
        bit got;
        got = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = DW'(v);
        bus.s_last  = last;
        for (int i = 0; i < 20 && !got; i++) begin
            got = (bus.s_ready === 1'b1);
            tick();
        end
        check("beat_accepted", got, 1);
        if (got) begin
            exp_img[k / AL][k % AL] = v;
            k++;
            if (last || k == N) k = 0;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    function automatic int rnd_pix();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Called in the START cycle: finish the frame via a comp_ready 1->0->1 sequence.
    task automatic do_done(input bit early, input bit hold);
        int d0;
        int s0;
        d0 = n_done;
        s0 = n_start;
        comp_ready = 1'b0;
        if (hold) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 16'sh7FFF;
        end
        tick();
        check("start_one_cycle", start_comp, 0);
        check("ready_low_in_wait", bus.s_ready, 0);
        if (early) begin
            comp_ready = 1'b1;
            tick();
            tick();
            check("first_wait_cycle_ignored", n_done, d0);
            comp_ready = 1'b0;
            tick();
        end else begin
            tick();
        end
        check("no_done_before_rise", n_done, d0);
        check_img("img_hold_in_wait");
        bus.s_valid = 1'b0;
        comp_ready  = 1'b1;
        tick();
        check("frame_done_on_rise", frame_done, 1);
        check("done_count", n_done, d0 + 1);
        check("ready_after_done", bus.s_ready, 1);
        tick();
        check("frame_done_one_cycle", frame_done, 0);
        check("no_extra_start", n_start, s0);
    endtask

    initial begin
        int s0;
        int d0;
        int e0;
        int v;
        clear_model();
        reset_n     = 1'b0;
        comp_ready  = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        tick();
        tick();
        check("rst_ready", bus.s_ready, 0);
        check("rst_start", start_comp, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_err, 0);
        check_img("rst_img");
        reset_n = 1'b1;
        tick();
        check("ready_after_release", bus.s_ready, 1);
        n_start = 0; n_done = 0; n_err = 0;

        // Reference frame 5,-3,7,100 with s_last on the fourth beat.
        send_beat(5, 0);
        send_beat(-3, 0);
        send_beat(7, 0);
        send_beat(100, 1);
        check("f1_start_pulse", start_comp, 1);
        check("f1_ready_low", bus.s_ready, 0);
        check("f1_no_err", frame_err, 0);
        check("f1_start_count", n_start, 1);
        check_img("f1_img");
        do_done(1'b0, 1'b1);

        // Valid pattern 1,0,1,1,0,1 feeding four beats.
        send_beat(rnd_pix(), 0);
        idle(1);
        send_beat(rnd_pix(), 0);
        send_beat(rnd_pix(), 0);
        idle(1);
        send_beat(rnd_pix(), 1);
        check("gap_start_pulse", start_comp, 1);
        check_img("gap_img");
        do_done(1'b1, 1'b0);

        // Short frame 1,2,3 then a clean frame of 9s.
        s0 = n_start;
        send_beat(1, 0);
        send_beat(2, 0);
        send_beat(3, 1);
        check("short_err_pulse", frame_err, 1);
        check("short_no_start", start_comp, 0);
        check("short_ready_kept", bus.s_ready, 1);
        check_img("short_img");
        tick();
        check("short_err_one_cycle", frame_err, 0);
        check("short_start_count", n_start, s0);
        for (int i = 0; i < N; i++) send_beat(9, i == N - 1);
        check("nines_start", start_comp, 1);
        check_img("nines_img");
        do_done(1'b0, 1'b0);

        // Full frame without s_last: completes, error flagged alongside start.
        for (int i = 0; i < N; i++) send_beat(rnd_pix(), 0);
        check("nolast_start", start_comp, 1);
        check("nolast_err", frame_err, 1);
        check_img("nolast_img");
        do_done(1'b0, 1'b0);

        // Reset during WAIT_DONE aborts the frame.
        for (int i = 0; i < N; i++) send_beat(rnd_pix(), i == N - 1);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        clear_model();
        check_img("wait_rst_img");
        check("wait_rst_ready", bus.s_ready, 0);
        check("wait_rst_start", start_comp, 0);
        reset_n = 1'b1;
        d0 = n_done;
        s0 = n_start;
        comp_ready = 1'b0;
        tick();
        check("wait_rst_ready_back", bus.s_ready, 1);
        comp_ready = 1'b1;
        tick();
        tick();
        check("wait_rst_no_done", n_done, d0);
        check("wait_rst_no_start", n_start, s0);

        // Reset mid-LOAD: the next frame starts again at column 0.
        send_beat(rnd_pix(), 0);
        send_beat(rnd_pix(), 0);
        reset_n = 1'b0;
        tick();
        clear_model();
        reset_n = 1'b1;
        tick();
        check_img("load_rst_img");
        for (int i = 0; i < N; i++) send_beat(rnd_pix(), i == N - 1);
        check("load_rst_start", start_comp, 1);
        check_img("load_rst_frame_img");
        do_done(1'b0, 1'b0);

        // Randomised frames: random pixels, gaps, early or missing s_last.
        for (int f = 0; f < 8; f++) begin
            bit short_f;
            bit last_f;
            int len;
            short_f = ($urandom_range(0, 2) == 0);
            len = short_f ? int'($urandom_range(1, N - 1)) : N;
            last_f = short_f ? 1'b1 : 1'($urandom_range(0, 1));
            s0 = n_start;
            e0 = n_err;
            for (int b = 0; b < len; b++) begin
                idle(int'($urandom_range(0, 2)));
                v = rnd_pix();
                send_beat(v, (b == len - 1) ? last_f : 1'b0);
            end
            check("rnd_err", frame_err, short_f || !last_f);
            check("rnd_start", start_comp, !short_f);
            check_img("rnd_img");
            if (short_f) begin
                tick();
                check("rnd_short_no_start", n_start, s0);
            end else begin
                do_done(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            check("rnd_err_count", n_err, e0 + ((short_f || !last_f) ? 1 : 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
